digital_tube_driver: RTL and testbench
======================================

# digital_tube_driver

Memory-mapped driver for the Minisys 8-digit seven-segment tube bank, sitting directly downstream of the CPU controller's tube-write strobe. It captures store data into a display word and a control word, then time-multiplexes the eight digits with a free-running scan counter, producing active-low digit-enable and segment outputs for the board pins.

## Interface
- SCAN_DIVIDER, 23000, clock cycles each digit stays lit (≥2)
- iClk  in  1  CPU clock, rising edge
- iRstN  in  1  asynchronous active-low reset
- iDoTubeWrite  in  1  store to the tube device this cycle (controller strobe)
- iAddrLow  in  2  ALU result bits [3:2]: 00 data word, 01 control word, others ignored
- iWriteData  in  32  store data (rt value)
- oTubeEnable  out  8  digit enables, active-low, bit i = digit i (digit 0 rightmost)
- oTubeSegment  out  8  {dp,g,f,e,d,c,b,a}, active-low

One clock; reset is asynchronous and active-low.

## Operation
- Data register D[31:0]: digit i shows hex nibble D[4i+3:4i].
- Control register C: [7:0] digit enable mask (1 = shown), [15:8] decimal-point mask (1 = dp lit), [16] leading-zero blank; bits [31:17] ignored, not stored.
- Write: on iClk rising edge with iDoTubeWrite=1, iAddrLow=00 loads D; 01 loads C[16:0]; 10/11 no effect. iDoTubeWrite=0 never changes D or C.
- Scan counter cnt: 0..SCAN_DIVIDER-1, increments every cycle; at SCAN_DIVIDER-1 wraps to 0 and digit index idx (3 bits) increments, 7 wraps to 0.
- Segment decode (active-low, dp off): 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,8 80,9 90,A 88,b 83,C C6,d A1,E 86,F 8E. dp bit7 cleared when C[8+idx]=1.
- Digit idx is blank when C[idx]=0, or C[16]=1 and idx≠0 and D[31:4idx]==0. Blank: oTubeEnable=8'hFF, oTubeSegment=8'hFF.
- Non-blank: oTubeEnable = ~(8'b1<<idx), oTubeSegment = decoded pattern with dp.
- Exactly zero or one enable bit low at any time.

## Timing
- Reset (async, immediate): D=0, C=17'h000FF (all digits on, no dp, no blanking), cnt=0, idx=0, oTubeEnable=8'hFF, oTubeSegment=8'hFF.
- Outputs are registered from current D, C, idx: value on pins after edge k reflects register state before edge k (one-cycle latency).
- First edge after reset release: digit 0 enabled, showing 0 (oTubeEnable=FE, oTubeSegment=C0).
- Write latency: a write at edge k is visible on pins after edge k+1 for the currently scanned digit; no wait for scan wrap.
- Write coinciding with idx advance: both take effect at the same edge; next output uses new idx and new data.
- Digit dwell: SCAN_DIVIDER cycles; full frame 8·SCAN_DIVIDER cycles; no gap cycles between digits.
- Reset asserted mid-frame: outputs go FF/FF asynchronously; scan restarts at digit 0 after release.
- No backpressure: writes every cycle are accepted; last write wins.

## Test plan (SCAN_DIVIDER=4)
- Reset release, no writes -> after first edge FE/C0; enable steps FE,FD,FB,...,7F every 4 cycles, wraps to FE after 32 cycles, segments C0 throughout.
- Write data 32'h89AB_CDEF at addr 00 -> digits 0..7 show 8E,86,A1,C6,83,88,90,80; pattern updates one cycle after the write edge.
- Write control 32'h0000_0305 -> only digits 0 and 2 enabled (others FF/FF); digit 0 segment bit7=0, digit 1 dp mask ignored since blanked.
- Control 32'h0001_00FF with data 32'h0000_0040 -> digits 0,1 shown (C0, 99), digits 2..7 blank; data 0 -> only digit 0 shows C0.
- Write at addr 10 and iDoTubeWrite=0 with addr 00 -> D and C unchanged, scan unaffected.
- Assert iRstN low mid-digit 5 -> outputs FF/FF immediately, D/C back to reset values; after release resume at digit 0.

Source files
------------

// File: rtl/digital_tube_driver.sv
// digital_tube_driver: memory-mapped 8-digit seven-segment tube driver.
// Holds a display word and a control word and scans one digit at a time.
module digital_tube_driver #(
  parameter int SCAN_DIVIDER = 23000
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iDoTubeWrite,
  input  logic [1:0]  iAddrLow,
  input  logic [31:0] iWriteData,
  output logic [7:0]  oTubeEnable,
  output logic [7:0]  oTubeSegment
);
  localparam int CW = (SCAN_DIVIDER > 2) ? $clog2(SCAN_DIVIDER) : 1;
  logic [31:0]   d;
  logic [16:0]   c;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic [7:0]    dpm;
  logic          blank;
  logic          wrap;
  always_comb begin
    nib = d[{idx, 2'b00} +: 4];
    dpm = c[15:8];
    wrap = cnt == CW'(SCAN_DIVIDER - 1);
    // leading-zero blanking looks at this digit and everything to its left
    blank = !c[idx] || (c[16] && idx != 3'd0 && (d >> {idx, 2'b00}) == 32'd0);
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      d            <= '0;
      c            <= 17'h000FF;
      cnt          <= '0;
      idx          <= '0;
      oTubeEnable  <= 8'hFF;
      oTubeSegment <= 8'hFF;
    end else begin
      if (iDoTubeWrite && iAddrLow == 2'b00) d <= iWriteData;
      if (iDoTubeWrite && iAddrLow == 2'b01) c <= iWriteData[16:0];
      cnt          <= wrap ? '0 : cnt + 1'b1;
      idx          <= wrap ? idx + 1'b1 : idx;
      oTubeEnable  <= blank ? 8'hFF : ~(8'b1 << idx);
      oTubeSegment <= blank ? 8'hFF : {~dpm[idx], seg};
    end
  end
endmodule

// File: tb/tb_digital_tube_driver.sv
// tb_digital_tube_driver: randomized scoreboard bench for digital_tube_driver.
// The model tracks D, C and elapsed cycles; the scanned digit is derived arithmetically.
module tb_digital_tube_driver;
  localparam int SD = 4;
  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic        iDoTubeWrite = 1'b0;
  logic [1:0]  iAddrLow = 2'b00;
  logic [31:0] iWriteData = '0;
  logic [7:0]  oTubeEnable, oTubeSegment;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] q[$];
  logic [31:0] m_d;
  logic [16:0] m_c;
  int unsigned cyc;
  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  digital_tube_driver #(.SCAN_DIVIDER(SD)) dut (
    .iClk(iClk), .iRstN(iRstN), .iDoTubeWrite(iDoTubeWrite), .iAddrLow(iAddrLow),
    .iWriteData(iWriteData), .oTubeEnable(oTubeEnable), .oTubeSegment(oTubeSegment)
  );

  always #5 iClk = ~iClk;

  function automatic logic [15:0] model_out();
    int i;
    logic [7:0] s;
    i = int'((cyc / SD) % 8);
    if (!m_c[i] || (m_c[16] && i != 0 && (m_d >> (4 * i)) == 0)) return 16'hFFFF;
    s = seg_tab[(m_d >> (4 * i)) & 32'hF];
    if (m_c[8 + i]) s[7] = 1'b0;
    return {~(8'b1 << i), s};
  endfunction

  task automatic step(input logic we, input logic [1:0] a, input logic [31:0] wd);
    iDoTubeWrite = we;
    iAddrLow = a;
    iWriteData = wd;
    @(posedge iClk);
    q.push_back(model_out());
    if (we && a == 2'b00) m_d = wd;
    if (we && a == 2'b01) m_c = wd[16:0];
    cyc++;
    #1;
    iDoTubeWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 32'h0);
  endtask

  task automatic check_reset_pins(input string name);
    checks++;
    if ({oTubeEnable, oTubeSegment} !== 16'hFFFF) begin
      errors++;
      $display("FAIL %s got=%h%h exp=ffff", name, oTubeEnable, oTubeSegment);
    end
  endtask

  always @(negedge iClk) begin
    if (q.size() > 0) begin
      logic [15:0] e;
      e = q.pop_front();
      checks++;
      if ({oTubeEnable, oTubeSegment} !== e)  begin
        errors++;
        $display("FAIL scan cyc=%0d got=%h%h exp=%h", cyc, oTubeEnable, oTubeSegment, e);
      end
    end
  end

  initial begin
    m_d = '0;
    m_c = 17'h000FF;
    cyc = 0;
    #12;
    check_reset_pins("reset_state");
    @(negedge iClk);
    #1 iRstN = 1'b1;
    idle(40);
    step(1'b1, 2'b00, 32'h89AB_CDEF);
    idle(40);
    step(1'b1, 2'b01, 32'h0000_0305);
    idle(40);
    step(1'b1, 2'b01, 32'h0001_00FF);
    step(1'b1, 2'b00, 32'h0000_0040);
    idle(40);
    step(1'b1, 2'b00, 32'h0000_0000);
    idle(40);
    step(1'b1, 2'b00, 32'h1234_5678);
    step(1'b1, 2'b01, 32'hFFFE_A5FF);
    idle(10);
    step(1'b1, 2'b10, 32'hDEAD_BEEF);
    step(1'b1, 2'b11, 32'h0000_0000);
    step(1'b0, 2'b00, 32'h0000_0000);
    step(1'b0, 2'b01, 32'h0000_0000);
    idle(40);
    while (((cyc / SD) % 8) != 5 || (cyc % SD) != 1) step(1'b0, 2'b00, 32'h0);
    @(negedge iClk);
    #1 iRstN = 1'b0;
    #1 check_reset_pins("async_reset");
    m_d = '0;
    m_c = 17'h000FF;
    cyc = 0;
    @(negedge iClk);
    check_reset_pins("reset_hold");
    #1 iRstN = 1'b1;
    idle(40);
    for (int k = 0; k < 1500; k++) begin
      int r;
      logic [1:0] a;
      logic [31:0] wd;
      r = int'($urandom_range(0, 9));
      a = 2'($urandom_range(0, 3));
      wd = $urandom >> $urandom_range(0, 31);
      if (a == 2'b01) wd = $urandom;
      step(r < 2, a, wd);
    end
    @(negedge iClk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
